// File: rtl/npu_job_master.sv
// Host-side job sequencer for npu_top: loads one job, pulses START, waits for DONE
// under a watchdog, then drains RES_COUNT bytes from the NPU FIFO onto a result stream.
module npu_job_master #(
    parameter int TIMEOUT_CYC = 100,
    parameter int RES_COUNT   = 4
) (
    input  logic        CLKEXT,
    input  logic        RST_GLO,
    input  logic        JOB_VALID,
    output logic        JOB_READY,
    input  logic [31:0] JOB_DATA,
    input  logic [15:0] JOB_BIAS1,
    input  logic [15:0] JOB_BIAS2,
    input  logic [15:0] JOB_SSFR,
    input  logic [15:0] JOB_CON,
    output logic        START,
    output logic [7:0]  DA,
    output logic [7:0]  DB,
    output logic [7:0]  DC,
    output logic [7:0]  DD,
    output logic [15:0] BIAS_N1,
    output logic [15:0] BIAS_N2,
    output logic [15:0] SSFR,
    output logic [15:0] CON_SIG,
    input  logic        DONE,
    input  logic        FIFO_EMPTY,
    input  logic [7:0]  D_OUT,
    output logic        FIFO_RD,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic [7:0]  RES_DATA,
    output logic        RES_LAST,
    output logic        JOB_DONE,
    output logic        ERR_TIMEOUT,
    output logic        HOST_BUSY
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_STRT  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_TOUT  = 3'd5;

    localparam logic [15:0] WDOG_TERM = 16'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  RES_CNT   = 8'(RES_COUNT);

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [15:0] wdog;
    logic [7:0]  popped;
    logic        rd_pending;
    logic        res_valid_q;
    logic        res_last_q;
    logic [7:0]  res_data_q;
    logic        ready_q;
    logic        err_q;
    logic        accept;
    logic        fifo_rd;
    logic        last_accept;
    logic        wdog_term;

    assign accept      = JOB_VALID & ready_q;
    assign wdog_term   = (wdog == WDOG_TERM);
    assign last_accept = (state == S_DRAIN) & res_valid_q & RES_READY & res_last_q;

    // Only one read in flight, and never pop while a result is still waiting on the consumer.
    assign fifo_rd = (state == S_DRAIN) & ~FIFO_EMPTY & ~rd_pending
                   & (~res_valid_q | RES_READY) & (popped < RES_CNT);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_SETUP;
            S_SETUP: state_next = S_STRT;
            S_STRT:  state_next = S_WAIT;
            S_WAIT: begin
                if (DONE)           state_next = S_DRAIN;
                else if (wdog_term) state_next = S_TOUT;
            end
            S_DRAIN: begin
                if (last_accept)                state_next = S_IDLE;
                else if (!fifo_rd && wdog_term) state_next = S_TOUT;
            end
            S_TOUT:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLKEXT or posedge RST_GLO) begin
        if (RST_GLO) begin
            state       <= S_IDLE;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            wdog        <= 16'd0;
            popped      <= 8'd0;
            rd_pending  <= 1'b0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_data_q  <= 8'd0;
            DA          <= 8'd0;
            DB          <= 8'd0;
            DC          <= 8'd0;
            DD          <= 8'd0;
            BIAS_N1     <= 16'd0;
            BIAS_N2     <= 16'd0;
            SSFR        <= 16'd0;
            CON_SIG     <= 16'd0;
        end else begin
            state   <= state_next;
            // Registered so JOB_READY stays low throughout reset and rises one edge later.
            ready_q <= (state_next == S_IDLE);

            if (accept) begin
                {DA, DB, DC, DD} <= JOB_DATA;
                BIAS_N1 <= JOB_BIAS1;
                BIAS_N2 <= JOB_BIAS2;
                SSFR    <= JOB_SSFR;
                CON_SIG <= JOB_CON;
                err_q   <= 1'b0;
            end else if (state_next == S_TOUT) begin
                err_q   <= 1'b1;
            end

            case (state)
                S_STRT: wdog <= 16'd0;
                S_WAIT: begin
                    if (DONE)                 wdog <= 16'd0;
                    else if (wdog != 16'hFFFF) wdog <= wdog + 16'd1;
                end
                S_DRAIN: begin
                    if (fifo_rd)              wdog <= 16'd0;
                    else if (wdog != 16'hFFFF) wdog <= wdog + 16'd1;
                end
                default: wdog <= wdog;
            endcase

            if (state == S_WAIT && DONE) popped <= 8'd0;
            else if (fifo_rd)            popped <= popped + 8'd1;

            rd_pending <= fifo_rd;

            if (state_next == S_TOUT) begin
                res_valid_q <= 1'b0;
                res_last_q  <= 1'b0;
            end else if (rd_pending) begin
                res_data_q  <= D_OUT;
                res_valid_q <= 1'b1;
                res_last_q  <= (popped == RES_CNT);
            end else if (res_valid_q && RES_READY) begin
                res_valid_q <= 1'b0;
                res_last_q  <= 1'b0;
            end
        end
    end

    assign JOB_READY   = ready_q;
    assign START       = (state == S_STRT);
    assign FIFO_RD     = fifo_rd;
    assign RES_VALID   = res_valid_q;
    assign RES_DATA    = res_data_q;
    assign RES_LAST    = res_last_q;
    assign JOB_DONE    = (state == S_TOUT) | last_accept;
    assign ERR_TIMEOUT = err_q;
    assign HOST_BUSY   = (state != S_IDLE);

endmodule

// File: tb/tb_npu_job_master.sv
// Randomized bench for npu_job_master with a behavioural NPU/FIFO model and
// per-job timing expectations derived from the job protocol.
module tb_npu_job_master;

    localparam int TO = 100;
    localparam int RC = 4;

    logic        CLKEXT = 1'b0;
    logic        RST_GLO;
    logic        JOB_VALID;
    logic        JOB_READY;
    logic [31:0] JOB_DATA;
    logic [15:0] JOB_BIAS1, JOB_BIAS2, JOB_SSFR, JOB_CON;
    logic        START;
    logic [7:0]  DA, DB, DC, DD;
    logic [15:0] BIAS_N1, BIAS_N2, SSFR, CON_SIG;
    logic        DONE;
    logic        FIFO_EMPTY;
    logic [7:0]  D_OUT;
    logic        FIFO_RD;
    logic        RES_VALID;
    logic        RES_READY;
    logic [7:0]  RES_DATA;
    logic        RES_LAST;
    logic        JOB_DONE;
    logic        ERR_TIMEOUT;
    logic        HOST_BUSY;

    always #5 CLKEXT = ~CLKEXT;

    npu_job_master #(.TIMEOUT_CYC(TO), .RES_COUNT(RC)) dut (
        .CLKEXT(CLKEXT), .RST_GLO(RST_GLO),
        .JOB_VALID(JOB_VALID), .JOB_READY(JOB_READY), .JOB_DATA(JOB_DATA),
        .JOB_BIAS1(JOB_BIAS1), .JOB_BIAS2(JOB_BIAS2), .JOB_SSFR(JOB_SSFR), .JOB_CON(JOB_CON),
        .START(START), .DA(DA), .DB(DB), .DC(DC), .DD(DD),
        .BIAS_N1(BIAS_N1), .BIAS_N2(BIAS_N2), .SSFR(SSFR), .CON_SIG(CON_SIG),
        .DONE(DONE), .FIFO_EMPTY(FIFO_EMPTY), .D_OUT(D_OUT), .FIFO_RD(FIFO_RD),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA), .RES_LAST(RES_LAST),
        .JOB_DONE(JOB_DONE), .ERR_TIMEOUT(ERR_TIMEOUT), .HOST_BUSY(HOST_BUSY)
    );

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({JOB_READY, START, DA, DB, DC, DD, BIAS_N1, BIAS_N2, SSFR, CON_SIG,
                     FIFO_RD, RES_VALID, RES_DATA, RES_LAST, JOB_DONE, ERR_TIMEOUT, HOST_BUSY});
    endfunction

    // NPU model, job request and per-job observations
    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  rd_data_next = 8'd0;
    logic [7:0]  prev_data = 8'd0;
    logic [31:0] jd = 32'd0;
    logic [15:0] jb1 = 16'd0, jb2 = 16'd0, js = 16'd0, jc = 16'd0;
    bit rd_last_cycle = 0, force_empty = 0, done_force = 0, hold_req = 0, hold_done = 0, job_req = 0;
    bit prev_valid = 0, prev_ready = 0, prev_rd = 0, err_at_done = 0;
    int cyc = 0, done_at = -1, done_delay = -1, hold_left = 0;
    int accept_cyc = -1, start_cyc = -1, start_cnt = 0, done_cnt = 0, done_cyc = -1;
    int dsamp_cyc = -1, beat_idx = 0, last_beat_cyc = -1, rd_cnt = 0;

    task automatic reset_model();
        fifo_q.delete();
        exp_q.delete();
        rd_last_cycle = 0; force_empty = 0; done_force = 0; hold_req = 0; hold_done = 0;
        hold_left = 0; job_req = 0; prev_valid = 0; prev_ready = 0; prev_rd = 0;
        done_at = -1; done_delay = -1; accept_cyc = -1; start_cyc = -1; start_cnt = 0;
        done_cnt = 0; done_cyc = -1; dsamp_cyc = -1; beat_idx = 0; last_beat_cyc = -1; rd_cnt = 0;
    endtask

    // One clock: drive inputs at the falling edge, observe 1ns later, update the model.
    task automatic step();
        @(negedge CLKEXT);
        cyc++;
        JOB_VALID = job_req;
        JOB_DATA  = job_req ? jd  : $urandom;
        JOB_BIAS1 = job_req ? jb1 : 16'($urandom);
        JOB_BIAS2 = job_req ? jb2 : 16'($urandom);
        JOB_SSFR  = job_req ? js  : 16'($urandom);
        JOB_CON   = job_req ? jc  : 16'($urandom);
        DONE       = done_force || (cyc == done_at);
        FIFO_EMPTY = force_empty || (fifo_q.size() == 0);
        D_OUT      = rd_last_cycle ? rd_data_next : 8'($urandom);
        if (hold_req && !hold_done && RES_VALID && beat_idx >= 1) begin
            hold_left = 10;
            hold_done = 1;
        end
        if (hold_left > 0) begin
            RES_READY = 1'b0;
            hold_left--;
        end else begin
            RES_READY = ($urandom_range(0, 3) != 0);
        end
        #1;
        if (JOB_VALID && JOB_READY) begin
            accept_cyc = cyc;
            job_req = 0;
        end
        if (START) begin
            start_cnt++;
            start_cyc = cyc;
            if (done_delay >= 0) done_at = cyc + done_delay;
        end
        if (DONE && start_cnt > 0 && dsamp_cyc < 0) dsamp_cyc = cyc;
        rd_last_cycle = FIFO_RD;
        if (FIFO_RD) begin
            checkOutput("rd_not_empty", 128'(FIFO_EMPTY), 128'(0));
            checkOutput("rd_after_done", 128'(dsamp_cyc >= 0 && cyc > dsamp_cyc), 128'(1));
            checkOutput("rd_spacing", 128'(prev_rd), 128'(0));
            checkOutput("rd_while_held", 128'(RES_VALID && !RES_READY), 128'(0));
            if (fifo_q.size() > 0) rd_data_next = fifo_q.pop_front();
            rd_cnt++;
        end
        if (prev_valid && !prev_ready) begin
            checkOutput("res_hold_valid", 128'(RES_VALID), 128'(1));
            checkOutput("res_hold_data", 128'(RES_DATA), 128'(prev_data));
        end
        if (RES_VALID && RES_READY) begin
            if (beat_idx < exp_q.size())
                checkOutput("res_data", 128'(RES_DATA), 128'(exp_q[beat_idx]));
            checkOutput("res_last", 128'(RES_LAST), 128'(beat_idx == RC - 1));
            beat_idx++;
            last_beat_cyc = cyc;
        end
        if (JOB_DONE) begin
            done_cnt++;
            done_cyc = cyc;
            err_at_done = ERR_TIMEOUT;
        end
        prev_valid = RES_VALID;
        prev_ready = RES_READY;
        prev_data  = RES_DATA;
        prev_rd    = FIFO_RD;
    endtask

    // mode 0: normal drain, 1: DONE never returned, 2: FIFO stays empty after DONE
    task automatic applyStimulus(input logic [31:0] data, input logic [15:0] b1, input logic [15:0] b2,
                                 input logic [15:0] s, input logic [15:0] c, input int dly,
                                 input int nbytes, input bit hold, input int mode);
        int n;
        start_cnt = 0; done_cnt = 0; beat_idx = 0; rd_cnt = 0; dsamp_cyc = -1; accept_cyc = -1;
        start_cyc = -1; done_cyc = -1; last_beat_cyc = -1; done_at = -1;
        done_delay = (mode == 1) ? -1 : dly;
        hold_req = hold; hold_done = 0; hold_left = 0;
        force_empty = (mode == 2);
        fifo_q.delete();
        exp_q.delete();
        for (int i = 0; i < nbytes; i++) begin
            fifo_q.push_back(8'($urandom));
            if (i < RC) exp_q.push_back(fifo_q[i]);
        end
        jd = data; jb1 = b1; jb2 = b2; js = s; jc = c;
        job_req = 1;
        n = 0;
        while (done_cnt == 0 && n < 500) begin
            step();
            n++;
            if (accept_cyc >= 0 && cyc == accept_cyc + 1) begin
                checkOutput("operands", 128'({DA, DB, DC, DD}), 128'(data));
                checkOutput("bias_cfg", 128'({BIAS_N1, BIAS_N2, SSFR, CON_SIG}), 128'({b1, b2, s, c}));
                checkOutput("setup_no_start", 128'(START), 128'(0));
                checkOutput("err_cleared", 128'(ERR_TIMEOUT), 128'(0));
                checkOutput("busy_ready", 128'({HOST_BUSY, JOB_READY}), 128'(2'b10));
            end
        end
        checkOutput("job_done_count", 128'(done_cnt), 128'(1));
        checkOutput("start_count", 128'(start_cnt), 128'(1));
        checkOutput("start_timing", 128'(start_cyc), 128'(accept_cyc + 2));
        if (mode == 0) begin
            checkOutput("beats", 128'(beat_idx), 128'(RC));
            checkOutput("done_on_last", 128'(done_cyc), 128'(last_beat_cyc));
            checkOutput("err_normal", 128'(err_at_done), 128'(0));
            checkOutput("reads", 128'(rd_cnt), 128'(RC));
            checkOutput("fifo_left", 128'(fifo_q.size()), 128'(nbytes - RC));
        end else begin
            // TO watched cycles after the reference point, then one TOUT cycle
            checkOutput("tout_timing", 128'(done_cyc),
                        128'(((mode == 1) ? start_cyc : dsamp_cyc) + TO + 1));
            checkOutput("err_timeout", 128'(err_at_done), 128'(1));
            checkOutput("tout_reads", 128'(rd_cnt), 128'(0));
            checkOutput("tout_beats", 128'(beat_idx), 128'(0));
        end
        step();
        checkOutput("ready_after_done", 128'({JOB_READY, HOST_BUSY}), 128'(2'b10));
        checkOutput("err_sticky", 128'(ERR_TIMEOUT), 128'(mode != 0));
        checkOutput("operands_kept", 128'({DA, DB, DC, DD, BIAS_N1, BIAS_N2, SSFR, CON_SIG}),
                    128'({data, b1, b2, s, c}));
        checkOutput("single_done", 128'(done_cnt), 128'(1));
    endtask

    initial begin
        int n;
        RST_GLO = 1'b1; JOB_VALID = 1'b0; JOB_DATA = '0; JOB_BIAS1 = '0; JOB_BIAS2 = '0;
        JOB_SSFR = '0; JOB_CON = '0; DONE = 1'b0; FIFO_EMPTY = 1'b1; D_OUT = '0; RES_READY = 1'b0;
        #12;
        checkOutput("reset_outputs", all_outs(), 128'(0));
        @(negedge CLKEXT);
        RST_GLO = 1'b0;
        step();
        checkOutput("ready_after_reset", 128'({JOB_READY, HOST_BUSY}), 128'(2'b10));

        $display("[TB] directed job 0x12345678");
        applyStimulus(32'h12345678, 16'h0010, 16'h0020, 16'h0001, 16'h0000, 5, RC, 0, 0);

        $display("[TB] consumer stall mid-drain");
        applyStimulus($urandom, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                      $urandom_range(1, 10), RC + 2, 1, 0);

        $display("[TB] DONE never returned");
        applyStimulus($urandom, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, RC, 0, 1);
        applyStimulus($urandom, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 3, RC, 0, 0);

        $display("[TB] FIFO empty after DONE");
        applyStimulus($urandom, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4, RC, 0, 2);

        $display("[TB] DONE while idle");
        done_force = 1;
        start_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("idle_done", 128'({START, HOST_BUSY, JOB_READY, FIFO_RD}), 128'(4'b0010));
        end
        done_force = 0;

        $display("[TB] reset during WAIT");
        reset_model();
        done_delay = -1;
        jd = $urandom; jb1 = 16'hBEEF; jb2 = 16'h1234; js = 16'h0F0F; jc = 16'h00FF;
        job_req = 1;
        n = 0;
        while (!(start_cyc >= 0 && cyc >= start_cyc + 3) && n < 20) begin
            step();
            n++;
        end
        checkOutput("reached_wait", 128'(HOST_BUSY), 128'(1));
        #3;
        RST_GLO = 1'b1;
        #1;
        checkOutput("async_reset", all_outs(), 128'(0));
        repeat (2) @(posedge CLKEXT);
        #1;
        checkOutput("held_reset", all_outs(), 128'(0));
        @(negedge CLKEXT);
        RST_GLO = 1'b0;
        reset_model();
        applyStimulus(32'hABCDEF01, 16'h0102, 16'h0304, 16'h0001, 16'h0005, 6, RC + 1, 0, 0);

        $display("[TB] random jobs");
        for (int k = 0; k < 6; k++) begin
            applyStimulus($urandom, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                          $urandom_range(1, 15), $urandom_range(RC, RC + 3), (k == 2), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
